// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   MEM-stage initiator for a word-wide data memory. The memory writes
//   synchronously and reads combinationally. The unit turns pipeline
//   load/store requests (LW/LH/LHU/LB/LBU/SW/SH/SB) into word accesses.
//   - Sub-word stores use a read-modify-write sequence.
//   - Loads are lane-selected and then sign- or zero-extended.
//   - The pipeline is stalled through o_req_ready while an access is in flight.
//
// Optional feature (build macro MAU_ALIGN_CHECK_EN):
//   defined   : misaligned LW/SW (addr[1:0]!=0) and LH/LHU/SH (addr[0]!=0)
//               are rejected with o_rsp_err=1 and no memory access.
//   undefined : the misaligned low address bits are forced to zero and the
//               access proceeds. o_rsp_err is then raised only for range errors.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, ACTIVE LOW
//   i_req_valid  request present
//   o_req_ready  unit can accept (IDLE only)
//   i_req_op     000 LW,001 LH,010 LHU,011 LB,100 LBU,101 SW,110 SH,111 SB
//   i_req_addr   byte address
//   i_req_wdata  store data (low byte/half used for SB/SH)
//   o_rsp_valid  one-cycle pulse when an access finishes
//   o_rsp_rdata  extended load data (0 for stores), held until next response
//   o_rsp_err    access rejected (misaligned / out of range), with o_rsp_valid
//   o_dm_addr    word-aligned address to the memory
//   o_dm_we      memory write enable
//   o_dm_din     memory write data
//   i_dm_dout    memory read data (combinational from o_dm_addr)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_dm_addr,
    output logic        o_dm_we,
    output logic [31:0] o_dm_din,
    input  logic [31:0] i_dm_dout
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    // The limit is one bit wider than the address, so MEM_WORDS*4 == 2^32
    // cannot wrap to zero.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_ERR
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    // ---------------- request decode (evaluated on the input side) ---------
    logic        w_is_word;
    logic        w_is_half;
    logic        w_range_err;
    logic        w_align_err;
    logic [31:0] w_addr_fix;

    assign w_is_word   = (i_req_op == OP_LW) || (i_req_op == OP_SW);
    assign w_is_half   = (i_req_op == OP_LH) || (i_req_op == OP_LHU) || (i_req_op == OP_SH);
    assign w_range_err = ({1'b0, i_req_addr} >= ADDR_LIMIT);

`ifdef MAU_ALIGN_CHECK_EN
    assign w_align_err = (w_is_word && (i_req_addr[1:0] != 2'b00)) ||
                         (w_is_half && i_req_addr[0]);
    assign w_addr_fix  = i_req_addr;
`else
    // Without the check, misalignment is silently corrected. Only the
    // address bits that a word or halfword access ignores are dropped.
    assign w_align_err = 1'b0;
    assign w_addr_fix  = w_is_word ? {i_req_addr[31:2], 2'b00} :
                         w_is_half ? {i_req_addr[31:1], 1'b0}  :
                                     i_req_addr;
`endif

    // ---------------- load lane selection / extension ----------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = i_dm_dout[7:0];
            2'd1:    w_byte = i_dm_dout[15:8];
            2'd2:    w_byte = i_dm_dout[23:16];
            default: w_byte = i_dm_dout[31:24];
        endcase
    end

    assign w_half = r_addr[1] ? i_dm_dout[31:16] : i_dm_dout[15:0];

    always_comb begin
        w_load_data = 32'h0;
        case (r_op)
            OP_LW:   w_load_data = i_dm_dout;
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'h0, w_half};
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'h0, w_byte};
            default: w_load_data = 32'h0;
        endcase
    end

    // ---------------- sub-word store merge ---------------------------------
    // The store data is replicated across the word, so every lane already
    // holds the right byte. Each lane then only has to choose between the
    // old memory byte and the replicated store byte.
    logic [31:0] w_lane_src;
    logic [3:0]  w_lane_en;
    logic [31:0] w_merged;

    assign w_lane_src = (r_op == OP_SB) ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_lane_en[gi] = (r_op == OP_SB) ? (r_addr[1:0] == LANE)
                                                   : (r_addr[1] == LANE[1]);
            assign w_merged[8*gi +: 8] = w_lane_en[gi] ? w_lane_src[8*gi +: 8]
                                                       : r_merge[8*gi +: 8];
        end
    endgenerate

    // ---------------- control FSM with registered response -----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LW;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_merge     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_op    <= i_req_op;
                        r_addr  <= w_addr_fix;
                        r_wdata <= i_req_wdata;
                        if (w_range_err || w_align_err)
                            r_state <= ST_ERR;
                        else if (i_req_op <= OP_LBU)
                            r_state <= ST_LOAD;
                        else if (i_req_op == OP_SW)
                            r_state <= ST_WRITE;
                        else
                            r_state <= ST_RMW_RD;
                    end
                end
                ST_LOAD: begin
                    r_rsp_rdata <= w_load_data;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_WRITE, ST_RMW_WR: begin
                    r_rsp_rdata <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_RMW_RD: begin
                    r_merge <= i_dm_dout;
                    r_state <= ST_RMW_WR;
                end
                ST_ERR: begin
                    r_rsp_rdata <= 32'h0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- memory-side outputs (decoded from state) -------------
    // The address is driven only in states that really touch memory. IDLE
    // and ERR present zero, so a rejected address never reaches the memory.
    always_comb begin
        o_dm_addr = 32'h0;
        o_dm_we   = 1'b0;
        o_dm_din  = 32'h0;
        case (r_state)
            ST_LOAD, ST_RMW_RD: begin
                o_dm_addr = {r_addr[31:2], 2'b00};
            end
            ST_WRITE: begin
                o_dm_addr = {r_addr[31:2], 2'b00};
                o_dm_we   = 1'b1;
                o_dm_din  = r_wdata;
            end
            ST_RMW_WR: begin
                o_dm_addr = {r_addr[31:2], 2'b00};
                o_dm_we   = 1'b1;
                o_dm_din  = w_merged;
            end
            default: ;
        endcase
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// - A table of request vectors is issued through one driver task.
// - Each vector pushes its expected response, completion cycle, write
//   count and resulting memory word to a scoreboard queue.
// - A monitor pops and compares those entries when the unit responds.
// - Hand-written sequences cover reset state, ignored requests while busy
//   and an asynchronous reset in the middle of a read-modify-write.
module tb_mem_access_unit;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_dm_addr   (dm_addr),
        .o_dm_we     (dm_we),
        .o_dm_din    (dm_din),
        .i_dm_dout   (dm_dout)
    );

    // ---------------- data memory model ----------------
    logic [31:0] mem [0:1023];
    logic        load_init;

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0]    <= 32'h12345678;
            mem[1]    <= 32'h8899AABB;
            mem[2]    <= 32'h11223344;
            mem[1023] <= 32'h7F008001;
        end else if (dm_we) begin
            mem[dm_addr[11:2]] <= dm_din;
        end
    end

    assign dm_dout = mem[dm_addr[11:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        logic        chk_mem;
        int          mem_idx;
        logic [31:0] mem_val;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          exp_we;
        logic        chk_mem;
        int          mem_idx;
        logic [31:0] mem_val;
    } sb_t;

    sb_t sb_q[$];
    int  we_cnt = 0;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input logic chk_mem,
                                input int mem_idx, input logic [31:0] mem_val);
        vec_t v;
        v.op        = op;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_err   = exp_err;
        v.lat       = (!exp_err && (op == OP_SH || op == OP_SB)) ? 3 : 2;
        v.chk_mem   = chk_mem;
        v.mem_idx   = mem_idx;
        v.mem_val   = mem_val;
        return v;
    endfunction

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        sb_t e;
        if (dm_we) we_cnt++;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check32("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb_q.pop_front();
                $display("txn %0d: cyc=%0d rdata=%h err=%0b", e.id, cyc, rsp_rdata, rsp_err);
                check32($sformatf("rdata[%0d]", e.id), rsp_rdata, e.rdata);
                check32($sformatf("err[%0d]", e.id), 32'(rsp_err), 32'(e.err));
                check32($sformatf("latency[%0d]", e.id), 32'(cyc), 32'(e.due));
                check32($sformatf("we_count[%0d]", e.id), 32'(we_cnt), 32'(e.exp_we));
                if (e.chk_mem)
                    check32($sformatf("mem[%0d]", e.id), mem[e.mem_idx], e.mem_val);
            end
            we_cnt = 0;
        end
    end

    // Driver. Always entered and left on a falling edge. It waits for ready
    // and then drives the request. It checks the busy window afterwards.
    // During the first busy cycle of a read-modify-write it drives a decoy
    // request, which the unit must ignore.
    task automatic issue(input vec_t v, input int id);
        sb_t e;
        int  waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check32($sformatf("ready_timeout[%0d]", id), 32'(req_ready), 32'h1);
            return;
        end
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.id      = id;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        e.due     = cyc + v.lat;
        e.exp_we  = (v.op >= OP_SW && !v.exp_err) ? 1 : 0;
        e.chk_mem = v.chk_mem;
        e.mem_idx = v.mem_idx;
        e.mem_val = v.mem_val;
        sb_q.push_back(e);
        @(negedge clk);
        check32($sformatf("busy1[%0d]", id), 32'(req_ready), 32'h0);
        if (v.lat == 3) begin
            req_op    = OP_SW;
            req_addr  = 32'h20;
            req_wdata = 32'hFFFFFFFF;
            @(negedge clk);
            check32($sformatf("busy2[%0d]", id), 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
    endtask

    vec_t vecs[25];

    initial begin
        int k;
        vecs[0]  = mk(OP_LB,  32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0, 0, 32'h0);
        vecs[1]  = mk(OP_LBU, 32'h5, 32'h0, 32'h000000AA, 1'b0, 1'b0, 0, 32'h0);
        vecs[2]  = mk(OP_LH,  32'h6, 32'h0, 32'hFFFF8899, 1'b0, 1'b0, 0, 32'h0);
        vecs[3]  = mk(OP_LHU, 32'h6, 32'h0, 32'h00008899, 1'b0, 1'b0, 0, 32'h0);
        vecs[4]  = mk(OP_LW,  32'h4, 32'h0, 32'h8899AABB, 1'b0, 1'b0, 0, 32'h0);
        vecs[5]  = mk(OP_LB,  32'h4, 32'h0, 32'hFFFFFFBB, 1'b0, 1'b0, 0, 32'h0);
        vecs[6]  = mk(OP_LBU, 32'h7, 32'h0, 32'h00000088, 1'b0, 1'b0, 0, 32'h0);
        vecs[7]  = mk(OP_LB,  32'h6, 32'h0, 32'hFFFFFF99, 1'b0, 1'b0, 0, 32'h0);
        vecs[8]  = mk(OP_LH,  32'h4, 32'h0, 32'hFFFFAABB, 1'b0, 1'b0, 0, 32'h0);
        vecs[9]  = mk(OP_SB,  32'hB, 32'h000000EE, 32'h0, 1'b0, 1'b1, 2, 32'hEE223344);
        vecs[10] = mk(OP_LW,  32'h8, 32'h0, 32'hEE223344, 1'b0, 1'b0, 0, 32'h0);
        vecs[11] = mk(OP_SW,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 4, 32'hDEADBEEF);
        vecs[12] = mk(OP_LW,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 0, 32'h0);
        vecs[13] = mk(OP_SH,  32'h2, 32'h0000CAFE, 32'h0, 1'b0, 1'b1, 0, 32'hCAFE5678);
        vecs[14] = mk(OP_LHU, 32'h2, 32'h0, 32'h0000CAFE, 1'b0, 1'b0, 0, 32'h0);
        vecs[15] = mk(OP_SB,  32'h0, 32'h12345601, 32'h0, 1'b0, 1'b1, 0, 32'hCAFE5601);
        vecs[16] = mk(OP_SW,  32'h1002, 32'h55555555, 32'h0, 1'b1, 1'b0, 0, 32'h0);
        vecs[17] = mk(OP_SB,  32'h1003, 32'h55555555, 32'h0, 1'b1, 1'b0, 0, 32'h0);
        vecs[18] = mk(OP_LB,  32'h1000, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0);
        vecs[19] = mk(OP_LW,  32'hFFC, 32'h0, 32'h7F008001, 1'b0, 1'b0, 0, 32'h0);
        vecs[20] = mk(OP_LH,  32'hFFE, 32'h0, 32'h00007F00, 1'b0, 1'b0, 0, 32'h0);
        vecs[21] = mk(OP_LB,  32'hFFC, 32'h0, 32'h00000001, 1'b0, 1'b0, 0, 32'h0);
`ifdef MAU_ALIGN_CHECK_EN
        vecs[22] = mk(OP_SW,  32'h6, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b1, 1, 32'h8899AABB);
        vecs[23] = mk(OP_LH,  32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0);
        vecs[24] = mk(OP_LW,  32'h7, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0);
`else
        vecs[22] = mk(OP_SW,  32'h6, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1, 32'hA5A5A5A5);
        vecs[23] = mk(OP_LH,  32'h5, 32'h0, 32'hFFFFA5A5, 1'b0, 1'b0, 0, 32'h0);
        vecs[24] = mk(OP_LW,  32'h7, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 0, 32'h0);
`endif

        // ---- reset ----
        rst_n     = 1'b0;
        load_init = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        load_init = 1'b0;
        check32("reset_ready", 32'(req_ready), 32'h1);
        check32("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check32("reset_rdata", rsp_rdata, 32'h0);
        check32("reset_err", 32'(rsp_err), 32'h0);
        check32("reset_dm_we", 32'(dm_we), 32'h0);
        check32("reset_dm_addr", dm_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table-driven transactions ----
        for (int i = 0; i < 25; i++) issue(vecs[i], i);

        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check32("drain_timeout", 32'(sb_q.size()), 32'h0);
        check32("idle_dm_addr", dm_addr, 32'h0);
        check32("idle_dm_din", dm_din, 32'h0);
        // The decoy store to word 8 must never have landed.
        check32("decoy_ignored", mem[8], 32'h0);

        // ---- asynchronous reset in the middle of RMW_RD of an SB ----
        we_cnt    = 0;
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h9;
        req_wdata = 32'h00000077;
        @(negedge clk);
        req_valid = 1'b0;
        check32("rmw_busy", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check32("abort_dm_we", 32'(dm_we), 32'h0);
        check32("abort_ready", 32'(req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check32($sformatf("abort_rsp_valid[%0d]", i), 32'(rsp_valid), 32'h0);
        end
        check32("abort_we_count", 32'(we_cnt), 32'h0);
        check32("abort_mem2", mem[2], 32'hEE223344);
        check32("abort_rdata", rsp_rdata, 32'h0);
        check32("abort_idle", 32'(req_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
